// File: rtl/vga_hex_text_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_hex_text_display: 640x480@60 VGA timing plus 16 x 4-digit hex renderer.
// Revision: 1.0
// ============================================================================
module vga_hex_text_display (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] data_raw,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic         p_tick,
    output logic [9:0]   x,
    output logic [9:0]   y,
    output logic [11:0]  rgb
);

    localparam logic [9:0] H_DISPLAY    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_DISPLAY    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
    localparam logic [11:0] COLOUR_FG   = 12'h0F0;
    localparam logic [11:0] COLOUR_BG   = 12'h000;

    // Each glyph packs rows 0..7 from the most significant byte down.
    localparam logic [63:0] FONT [16] = '{
        64'h003C666E76663C00, 64'h001838181818_7E00, 64'h003C660C18307E00,
        64'h003C661C06663C00, 64'h000C1C2C4C7E0C00, 64'h007E607C06663C00,
        64'h003C607C66663C00, 64'h007E060C18303000, 64'h003C663C66663C00,
        64'h003C66663E063C00, 64'h00183C667E666600, 64'h007C667C66667C00,
        64'h003C666060663C00, 64'h00786C66666C7800, 64'h007E607C60607E00,
        64'h007E607C60606000
    };

    logic [1:0]  div;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [5:0]  row;
    logic [6:0]  col;
    logic        in_text;
    logic [3:0]  word_idx;
    logic [1:0]  digit_idx;
    logic [15:0] word;
    logic [3:0]  nibble;
    logic [63:0] font_word;
    logic [2:0]  glyph_line;
    logic [7:0]  rom_data;
    logic [7:0]  glyph_row;
    logic        pixel_on;
    logic [11:0] colour;

    assign p_tick   = (div == 2'd3);
    assign video_on = (x < H_DISPLAY) && (y < V_DISPLAY);

    always_comb begin
        x_next = x;
        y_next = y;
        if (x == H_TOTAL - 10'd1) begin
            x_next = 10'd0;
            y_next = (y == V_TOTAL - 10'd1) ? 10'd0 : y + 10'd1;
        end else begin
            x_next = x + 10'd1;
        end
    end

    // Character cell lookup: word i sits at data_raw[255-16i -: 16], digit 0 is the top nibble.
    assign row        = y[9:4];
    assign col        = x[9:3];
    assign in_text    = (row >= 6'd1) && (row <= 6'd16) && (col >= 7'd1) && (col <= 7'd4);
    assign word_idx   = 4'(row - 6'd1);
    assign digit_idx  = 2'(col - 7'd1);
    assign word       = data_raw[{~word_idx, 4'b0000} +: 16];
    assign nibble     = word[{~digit_idx, 2'b00} +: 4];
    assign font_word  = FONT[nibble];
    assign glyph_line = y[3:1];
    assign rom_data   = font_word[{~glyph_line, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glyph_row <= 8'h00;
        end else begin
            glyph_row <= rom_data;
        end
    end

    assign pixel_on = glyph_row[~x[2:0]];
    assign colour   = (video_on && in_text && pixel_on) ? COLOUR_FG : COLOUR_BG;

    // Sync flags are derived from the next counters so they change together with x/y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div   <= 2'd0;
            x     <= 10'd0;
            y     <= 10'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= COLOUR_BG;
        end else begin
            div <= div + 2'd1;
            if (p_tick) begin
                x     <= x_next;
                y     <= y_next;
                hsync <= !((x_next >= H_SYNC_START) && (x_next <= H_SYNC_END));
                vsync <= !((y_next >= V_SYNC_START) && (y_next <= V_SYNC_END));
                rgb   <= colour;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_hex_text_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_hex_text_display: directed bench with a pixel-level reference model.
// Revision: 1.0
// ============================================================================
module tb_vga_hex_text_display;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] data_raw;
    logic         hsync, vsync, video_on, p_tick;
    logic [9:0]   x, y;
    logic [11:0]  rgb;

    vga_hex_text_display dut (
        .clk      (clk),
        .reset    (reset),
        .data_raw (data_raw),
        .hsync    (hsync),
        .vsync    (vsync),
        .video_on (video_on),
        .p_tick   (p_tick),
        .x        (x),
        .y        (y),
        .rgb      (rgb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;
    bit running  = 1'b0;

    logic [7:0] G0 [8] = '{8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h3C, 8'h00};
    logic [7:0] G1 [8] = '{8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    // Expected colour of pixel (px,py); dc marks glyph interiors whose shape is free.
    function automatic void colour_of(input int px, input int py, output bit lit, output bit dc);
        int r, c, digit, gl, b;
        logic [15:0] w;
        lit = 1'b0;
        dc  = 1'b0;
        if (px >= 640 || py >= 480) return;
        r = py / 16;
        c = px / 8;
        if (r < 1 || r > 16 || c < 1 || c > 4) return;
        w     = data_raw[255 - 16 * (r - 1) -: 16];
        digit = int'((w >> (4 * (4 - c))) & 16'hF);
        gl    = (py % 16) / 2;
        b     = 7 - (px % 8);
        if (digit == 0)      lit = G0[gl][b];
        else if (digit == 1) lit = G1[gl][b];
        else if (gl != 0 && gl != 7 && b != 7 && b != 0) dc = 1'b1;
    endfunction

    int pix, ex, ey, pp, px, py;
    bit pend_lit = 1'b0, pend_dc = 1'b0, exp_lit = 1'b0, exp_dc = 1'b0;
    logic [7:0] f_row = 8'h00;

    always @(posedge clk) if (running) n <= n + 1;

    always @(negedge clk) begin
        if (running) begin
            pix = n / 4;
            ex  = pix % 800;
            ey  = (pix / 800) % 525;
            if (n > 0 && n % 4 == 0) begin
                exp_lit = pend_lit;
                exp_dc  = pend_dc;
            end
            check("x", x, ex);
            check("y", y, ey);
            check("p_tick", p_tick, (n % 4 == 3));
            check("hsync", hsync, !(ex >= 656 && ex <= 751));
            check("vsync", vsync, !(ey >= 490 && ey <= 491));
            check("video_on", video_on, (ex < 640 && ey < 480));
            if (exp_dc) check("rgb_glyph_colour", (rgb == 12'h000 || rgb == 12'h0F0), 1'b1);
            else        check("rgb", rgb, exp_lit ? 12'h0F0 : 12'h000);

            if (n == 2)              check("ptick_not_3rd", p_tick, 1'b0);
            if (n == 3)              check("ptick_4th_clk", p_tick, 1'b1);
            if (n == 4)              check("x_after_first_tick", x, 10'd1);
            if (n == 4 * 656 - 1)    check("hsync_before_656", hsync, 1'b1);
            if (n == 4 * 656)        check("hsync_fall_656", hsync, 1'b0);
            if (n == 4 * 751)        check("hsync_low_751", hsync, 1'b0);
            if (n == 4 * 752)        check("hsync_rise_752", hsync, 1'b1);
            if (n == 4 * 640 - 1)    check("video_on_639", video_on, 1'b1);
            if (n == 4 * 640)        check("video_off_640", video_on, 1'b0);
            if (n == 3199)           check("x_799", {y, x}, {10'd0, 10'd799});
            if (n == 3200)           check("x_wrap", {y, x}, {10'd1, 10'd0});
            if (n == 4 * (6 * 800 + 11))  check("row0_blank", rgb, 12'h000);
            if (n == 4 * (18 * 800 + 9))  check("pix_8_18", rgb, 12'h000);
            if (n == 4 * (18 * 800 + 10)) check("pix_9_18", rgb, 12'h000);
            if (n == 4 * (18 * 800 + 11)) check("pix_10_18", rgb, 12'h0F0);
            if (n == 4 * (18 * 800 + 14)) check("pix_13_18", rgb, 12'h0F0);
            if (n == 4 * (18 * 800 + 15)) check("pix_14_18", rgb, 12'h000);
            if (n == 4 * (18 * 800 + 35)) check("pix_34_18", rgb, 12'h0F0);
            if (n == 4 * (18 * 800 + 43)) check("col5_blank", rgb, 12'h000);

            if (n > 0 && n % 4 == 0) begin
                pp = pix - 1;
                px = pp % 800;
                py = pp / 800;
                if (py == 22 && px >= 8 && px <= 15) f_row[15 - px] = (rgb == 12'h0F0);
            end
            if (n % 4 == 3) colour_of(ex, ey, pend_lit, pend_dc);
        end
    end

    task automatic wait_n(input int k);
        while (n < k) @(negedge clk);
    endtask

    initial begin
        data_raw = '1;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_x", x, 10'd0);
        check("reset_y", y, 10'd0);
        check("reset_rgb", rgb, 12'h000);
        check("reset_syncs", {hsync, vsync}, 2'b11);
        check("reset_ptick", p_tick, 1'b0);
        check("reset_video_on", video_on, 1'b1);

        reset   = 1'b1;
        running = 1'b1;

        wait_n(4 * (10 * 800 + 400));
        data_raw[255 -: 16] = 16'h0000;
        data_raw[239 -: 16] = 16'h0001;

        // Switch mid-cell, right after a pixel boundary, to exercise live sampling.
        wait_n(4 * (21 * 800 + 9));
        data_raw[255 -: 16] = 16'hF000;

        wait_n(4 * (23 * 800 + 550));
        check("pre_reset_x", x, 10'd550);
        #2;
        running = 1'b0;
        reset   = 1'b0;
        #1;
        check("async_reset_xy", {y, x}, 20'd0);
        check("async_reset_rgb", rgb, 12'h000);
        check("async_reset_syncs", {hsync, vsync}, 2'b11);
        check("async_reset_ptick", p_tick, 1'b0);

        check("f_glyph_nonblank", (f_row != 8'h00), 1'b1);
        check("f_glyph_not_zero_shape", (f_row != 8'h6E), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
